// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: board clock rate and the
// constant-function helpers used to size the debounce counters.
package input_conditioner_pkg;

   // Board system clock; board top level derives DEBOUNCE_CYCLES from this.
   localparam int unsigned CLOCK_FREQUENCY = 16_000_000;

   // Ceiling log2 usable in constant expressions; clog2(0) = clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   // Debounce counter width: enough to hold DEBOUNCE_CYCLES-1, never zero.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      w = clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One conditioned input: synchroniser chain, debounce counter and the
// registered level / rise / fall outputs.
module input_conditioner_channel
   import input_conditioner_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16000,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   level_q;
   logic                   level_d;
   logic                   rise_q;
   logic                   rise_d;
   logic                   fall_q;
   logic                   fall_d;

   // Shift din into the chain; din is read nowhere else in this block.
   always_comb begin
      sync_d = SYNC_STAGES'({sync_q, din});
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Debounce: a difference must persist for DEBOUNCE_CYCLES consecutive
   // cycles; any return to the current level discards the partial count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = s;
            rise_d  = s;
            fall_d  = ~s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; the chain resets to the level so release never strobes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: one independent channel per board input,
// plus a combined edge indication for all channels.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int unsigned         CHANNELS        = 2,
   parameter int unsigned         SYNC_STAGES     = 2,
   parameter int unsigned         DEBOUNCE_CYCLES = 16000,
   parameter logic [CHANNELS-1:0] RESET_VALUE     = '0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_edge
);

   // Channels share nothing but the clock and reset.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      input_conditioner_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (RESET_VALUE[gi])
      ) u_chan (
         .clock (clock),
         .reset (reset),
         .din   (din[gi]),
         .level (level[gi]),
         .rise  (rise[gi]),
         .fall  (fall[gi])
      );
   end

   // Strobes are already registered, so this adds no further latency.
   assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a window-based model.
module tb_input_conditioner;

   localparam int         SYNC_A = 2;
   localparam int         DEB_A  = 4;
   localparam int         SYNC_B = 1;
   localparam int         DEB_B  = 1;
   localparam logic [1:0] RV     = 2'b10;
   localparam int         HIST   = 16384;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] din_a = 2'b01;
   logic [1:0] din_b = 2'b00;
   logic [1:0] level_a, rise_a, fall_a;
   logic [1:0] level_b, rise_b, fall_b;
   logic       any_a, any_b;

   always #5 clock = ~clock;

   input_conditioner #(
      .CHANNELS(2), .SYNC_STAGES(SYNC_A), .DEBOUNCE_CYCLES(DEB_A), .RESET_VALUE(RV)
   ) dut_a (
      .clock(clock), .reset(reset), .din(din_a),
      .level(level_a), .rise(rise_a), .fall(fall_a), .any_edge(any_a)
   );

   input_conditioner #(
      .CHANNELS(2), .SYNC_STAGES(SYNC_B), .DEBOUNCE_CYCLES(DEB_B), .RESET_VALUE(RV)
   ) dut_b (
      .clock(clock), .reset(reset), .din(din_b),
      .level(level_b), .rise(rise_b), .fall(fall_b), .any_edge(any_b)
   );

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;
   int strobes_a = 0;
   int rise0_a   = 0;
   logic [1:0] rv_bits = RV;

   // Model: din history per instance since reset release; level flips at an
   // edge when the synchronised value differed from level on each of the last
   // DEB edges, all of them after the previous flip.
   logic [1:0] hist [2][HIST];
   int         n_edge [2];
   int         last_chg [2][2];
   logic [1:0] m_level [2];
   logic [1:0] m_rise [2];
   logic [1:0] m_fall [2];

   function automatic int sync_of(input int inst);
      return (inst == 0) ? SYNC_A : SYNC_B;
   endfunction

   function automatic int deb_of(input int inst);
      return (inst == 0) ? DEB_A : DEB_B;
   endfunction

   // Synchronised value seen by the filter at edge k: din from SYNC edges back.
   function automatic logic s_used(input int inst, input int k, input int ch);
      int j;
      j = k - sync_of(inst);
      if (j < 0) return rv_bits[ch];
      return hist[inst][j][ch];
   endfunction

   task automatic model_reset();
      for (int inst = 0; inst < 2; inst++) begin
         n_edge[inst]  = 0;
         m_level[inst] = rv_bits;
         m_rise[inst]  = 2'b00;
         m_fall[inst]  = 2'b00;
         for (int ch = 0; ch < 2; ch++) last_chg[inst][ch] = -1;
      end
   endtask

   task automatic model_step(input int inst, input logic [1:0] d);
      int  k;
      int  deb;
      bit  flip;
      k   = n_edge[inst];
      deb = deb_of(inst);
      hist[inst][k] = d;
      m_rise[inst] = 2'b00;
      m_fall[inst] = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
         flip = (k - deb + 1) > last_chg[inst][ch];
         for (int j = k - deb + 1; j <= k; j++) begin
            if (flip && s_used(inst, j, ch) == m_level[inst][ch]) flip = 1'b0;
         end
         if (flip) begin
            m_level[inst][ch] = ~m_level[inst][ch];
            if (m_level[inst][ch]) m_rise[inst][ch] = 1'b1;
            else                   m_fall[inst][ch] = 1'b1;
            last_chg[inst][ch] = k;
         end
      end
      if (n_edge[inst] < HIST - 1) n_edge[inst] = n_edge[inst] + 1;
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         model_reset();
      end else begin
         model_step(0, din_a);
         model_step(1, din_b);
      end
   end

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (check_en) begin
         check("a_level", level_a, m_level[0]);
         check("a_rise",  rise_a,  m_rise[0]);
         check("a_fall",  fall_a,  m_fall[0]);
         check("a_any",   {1'b0, any_a}, {1'b0, |(m_rise[0] | m_fall[0])});
         check("b_level", level_b, m_level[1]);
         check("b_rise",  rise_b,  m_rise[1]);
         check("b_fall",  fall_b,  m_fall[1]);
         check("b_any",   {1'b0, any_b}, {1'b0, |(m_rise[1] | m_fall[1])});
         if (any_a)     strobes_a = strobes_a + 1;
         if (rise_a[0]) rise0_a   = rise0_a + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      int snap;
      int hold;
      logic [5:0] bounce;

      // Reset held with din differing from RESET_VALUE.
      reset = 1'b0;
      din_a = 2'b01;
      din_b = 2'b00;
      repeat (3) tick();
      check_en = 1'b1;
      check("rst_level", level_a, 2'b10);
      check("rst_strobe", rise_a | fall_a, 2'b00);
      check("rst_any", {1'b0, any_a}, 2'b00);

      // Release: no strobe on the release cycle, change after edge 5.
      reset = 1'b1;
      check("rel_level", level_a, 2'b10);
      check("rel_any", {1'b0, any_a}, 2'b00);
      for (int k = 0; k <= 6; k++) begin
         tick();
         if (k < 5) begin
            check("rel_wait_level", level_a, 2'b10);
            check("rel_wait_any", {1'b0, any_a}, 2'b00);
         end else if (k == 5) begin
            check("rel_new_level", level_a, 2'b01);
            check("rel_rise", rise_a, 2'b01);
            check("rel_fall", fall_a, 2'b10);
            check("rel_any_hi", {1'b0, any_a}, 2'b01);
         end else begin
            check("rel_any_lo", {1'b0, any_a}, 2'b00);
         end
      end

      // Clean step on channel 0.
      din_a = 2'b00;
      repeat (10) tick();
      din_a = 2'b01;
      for (int k = 0; k <= 6; k++) begin
         tick();
         if (k == 4) check("step_before", level_a, 2'b00);
         if (k == 5) begin
            check("step_level", level_a, 2'b01);
            check("step_rise", rise_a, 2'b01);
            check("step_fall", fall_a, 2'b00);
         end
         if (k == 6) check("step_rise_off", rise_a, 2'b00);
      end

      // Repeated 3-cycle glitches never pass the filter.
      din_a = 2'b00;
      repeat (10) tick();
      snap = strobes_a;
      repeat (20) begin
         din_a = 2'b01;
         repeat (3) tick();
         din_a = 2'b00;
         repeat (3) tick();
      end
      repeat (6) tick();
      check("glitch_level", level_a, 2'b00);
      check("glitch_strobes", 2'(strobes_a - snap), 2'b00);

      // Bounce 1,0,1,1,1,1: single rise 4 cycles after s settles.
      bounce = 6'b111101;
      snap = rise0_a;
      for (int k = 0; k < 12; k++) begin
         din_a[0] = (k < 6) ? bounce[k] : 1'b1;
         tick();
         if (k == 6) check("bounce_before", {1'b0, level_a[0]}, 2'b00);
         if (k == 7) check("bounce_rise", rise_a, 2'b01);
      end
      check("bounce_count", 2'(rise0_a - snap), 2'b01);

      // Reset mid-count (cnt=2 after edge 3) acts without a clock edge.
      din_a = 2'b00;
      repeat (4) tick();
      reset = 1'b0;
      #1;
      check("midrst_level", level_a, 2'b10);
      check("midrst_strobe", rise_a | fall_a, 2'b00);
      repeat (2) tick();
      reset = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         tick();
         if (k < 5) check("midrst_wait", level_a, 2'b10);
         else begin
            check("midrst_level_new", level_a, 2'b00);
            check("midrst_fall", fall_a, 2'b10);
            check("midrst_rise", rise_a, 2'b00);
         end
      end

      // Unfiltered instance: toggling every cycle strobes every cycle.
      din_b = 2'b00;
      repeat (4) tick();
      for (int i = 0; i < 12; i++) begin
         din_b[0] = 1'(i % 2);
         tick();
         if (i >= 2) begin
            check("tog_level", {1'b0, level_b[0]}, 2'((i - 1) % 2));
            check("tog_rise",  {1'b0, rise_b[0]},  2'((i - 1) % 2));
            check("tog_fall",  {1'b0, fall_b[0]},  2'(i % 2));
         end
      end

      // Randomized phase with occasional asynchronous resets.
      for (int r = 0; r < 400; r++) begin
         if ($urandom_range(0, 40) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
         din_a = 2'($urandom);
         hold = $urandom_range(1, 9);
         repeat (hold) begin
            din_b = 2'($urandom);
            tick();
         end
      end

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
